pitch_tracker: RTL and testbench
================================

PITCH_TRACKER -- requirements
Module: pitch_tracker

Interface
REQ-001 Parameter WIDTH, default 18, bit width of the period counter and of counter_top.
REQ-002 Parameter DEBOUNCE, default 4, number of consecutive cycles the synchronized input must differ from the filtered level before a level change is accepted.
REQ-003 Parameter STABLE_COUNT, default 3, number of consecutive in-tolerance measurements required to assert locked.
REQ-004 Parameter TOL_SHIFT, default 5, tolerance exponent; a measurement is in tolerance when |new - prev| <= prev >> TOL_SHIFT.
REQ-005 clk  input  1  system clock; the only clock.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 sig_in  input  1  asynchronous square wave, e.g. an oscillator output or a pwmout pin.
REQ-008 counter_top  output  WIDTH  last measured half-period minus 1, in clk cycles; same encoding as oscillator counter_top.
REQ-009 valid  output  1  one-cycle strobe when counter_top is updated.
REQ-010 locked  output  1  high while the last STABLE_COUNT consecutive compared measurements were in tolerance.
REQ-011 gate  output  1  high while a tone is present (state RUNNING).

Function
REQ-012 sig_in shall pass through a two-flop synchronizer before any use.
REQ-013 Debounce: the filtered level shall change only after the synchronized input differs from it for DEBOUNCE consecutive cycles; any shorter excursion resets the debounce count and is ignored.
REQ-014 An edge event shall be flagged for exactly one cycle on each change of the filtered level, rising or falling.
REQ-015 Period counter: increments every cycle outside SILENT; clears to 0 on an accepted edge; saturates at all-ones.
REQ-016 The FSM shall have three states: SILENT, ARMED and RUNNING.
REQ-017 SILENT: on an edge, go to ARMED and clear the period counter; no valid is issued.
REQ-018 ARMED or RUNNING: on an edge, load counter_top with the current counter value (half-period minus 1), pulse valid the following cycle, clear the counter, and go to RUNNING.
REQ-019 Timeout: when the counter equals all-ones, go to SILENT, clear locked and the stability count, and hold counter_top.
REQ-020 Timeout and edge in the same cycle: timeout takes priority, and the edge is then processed as a SILENT-state edge, entering ARMED.
REQ-021 Stability: the first measurement after SILENT sets the stability count to 0; each later measurement increments it (saturating at STABLE_COUNT) if in tolerance against the previous counter_top, otherwise clears it to 0.
REQ-022 Tolerance arithmetic: the difference shall be computed unsigned at WIDTH+1 bits with no wrap.
REQ-023 locked shall equal (stability count == STABLE_COUNT), registered, and update in the same cycle as valid.
REQ-024 gate shall equal (state == RUNNING), registered.

Reset
REQ-025 While rst is high: state shall be SILENT, and counter_top, valid, locked, gate, the stability count, the period counter, the debounce count, the synchronizer flops and the filtered level shall all be 0.
REQ-026 An assertion of rst mid-measurement shall discard the partial period; the first edge after release only arms the FSM.

Verification
REQ-027 Reset: assert rst for 3 cycles -> counter_top=0, valid=0, locked=0, gate=0; then sig_in idle -> outputs stay 0.
REQ-028 Square wave, half-period 1000 clk -> first valid gives counter_top=999 and gate=1; locked=1 on the 4th valid, with exactly one valid per edge.
REQ-029 While locked at 1000, inject a 3-cycle glitch mid-half-period -> no valid, counter_top=999, locked stays 1.
REQ-030 Switch to half-period 500 -> next valid gives counter_top=499 with locked=0; locked=1 again on the 3rd following valid.
REQ-031 Hold sig_in constant -> 2^18-1 cycles after the last counter clear, gate=0 and locked=0, counter_top holds 499; the next edge gives no valid, and the one after gives a valid.
REQ-032 Half-period 1020 after 1000 (diff 20 <= 31) keeps locked=1; half-period 1040 (diff 40 > 31) clears locked.

Source files
------------

// File: rtl/pitch_tracker.sv
`default_nettype none
// ============================================================================
// Module      : pitch_tracker
// Description : Measures the half-period of an asynchronous square wave and
//               reports tone presence and a frequency-lock indication.
// Revision    : 1.0 - initial release
// ============================================================================
module pitch_tracker #(
    parameter int WIDTH        = 18,
    parameter int DEBOUNCE     = 4,
    parameter int STABLE_COUNT = 3,
    parameter int TOL_SHIFT    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [WIDTH-1:0] counter_top,
    output logic             valid,
    output logic             locked,
    output logic             gate
);

    localparam int DB_W = $clog2(DEBOUNCE + 1);
    localparam int ST_W = $clog2(STABLE_COUNT + 1);
    localparam logic [DB_W-1:0]  c_db_last = DB_W'(DEBOUNCE - 1);
    localparam logic [ST_W-1:0]  c_st_max  = ST_W'(STABLE_COUNT);
    localparam logic [WIDTH-1:0] c_cnt_max = '1;

    typedef enum logic [1:0] {
        SILENT  = 2'd0,
        ARMED   = 2'd1,
        RUNNING = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_sync1;
    logic              r_sync2;
    logic              r_level;
    logic              r_edge;
    logic [DB_W-1:0]   r_db_cnt;
    logic [WIDTH-1:0]  r_period;
    logic [ST_W-1:0]   r_stab;

    logic [WIDTH:0]    w_diff;
    logic              w_in_tol;
    logic [ST_W-1:0]   w_stab_next;
    logic              w_timeout;

    // Synchronizer and debounce filter; r_edge pulses with each accepted level change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_level  <= 1'b0;
            r_edge   <= 1'b0;
            r_db_cnt <= '0;
        end else begin
            r_sync1 <= sig_in;
            r_sync2 <= r_sync1;
            r_edge  <= 1'b0;
            if (r_sync2 != r_level) begin
                if (r_db_cnt == c_db_last) begin
                    r_level  <= r_sync2;
                    r_db_cnt <= '0;
                    r_edge   <= 1'b1;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    // Absolute difference is taken one bit wider so it can never wrap
    always_comb begin
        if (r_period >= counter_top) begin
            w_diff = {1'b0, r_period} - {1'b0, counter_top};
        end else begin
            w_diff = {1'b0, counter_top} - {1'b0, r_period};
        end
        w_in_tol = (w_diff <= {1'b0, counter_top >> TOL_SHIFT});
        if (!w_in_tol) begin
            w_stab_next = '0;
        end else if (r_stab == c_st_max) begin
            w_stab_next = r_stab;
        end else begin
            w_stab_next = r_stab + 1'b1;
        end
    end

    assign w_timeout = (r_state != SILENT) && (r_period == c_cnt_max);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= SILENT;
            r_period    <= '0;
            r_stab      <= '0;
            counter_top <= '0;
            valid       <= 1'b0;
            locked      <= 1'b0;
            gate        <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (w_timeout) begin
                // A coincident edge is treated as the first edge of a new tone
                r_state  <= r_edge ? ARMED : SILENT;
                r_period <= '0;
                r_stab   <= '0;
                locked   <= 1'b0;
                gate     <= 1'b0;
            end else begin
                case (r_state)
                    SILENT: begin
                        if (r_edge) begin
                            r_state  <= ARMED;
                            r_period <= '0;
                        end
                    end
                    default: begin
                        if (r_edge) begin
                            counter_top <= r_period;
                            valid       <= 1'b1;
                            r_period    <= '0;
                            r_state     <= RUNNING;
                            gate        <= 1'b1;
                            if (r_state == ARMED) begin
                                r_stab <= '0;
                                locked <= (c_st_max == '0);
                            end else begin
                                r_stab <= w_stab_next;
                                locked <= (w_stab_next == c_st_max);
                            end
                        end else begin
                            r_period <= r_period + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pitch_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_pitch_tracker
// Description : Scoreboard bench for pitch_tracker with directed half-periods.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pitch_tracker;

    localparam int WIDTH = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic             sig_in;
    logic [WIDTH-1:0] counter_top;
    logic             valid;
    logic             locked;
    logic             gate;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [WIDTH-1:0] top;
        logic             lk;
        logic             gt;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    pitch_tracker #(
        .WIDTH        (WIDTH),
        .DEBOUNCE     (4),
        .STABLE_COUNT (3),
        .TOL_SHIFT    (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sig_in      (sig_in),
        .counter_top (counter_top),
        .valid       (valid),
        .locked      (locked),
        .gate        (gate)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Toggle the input, optionally queue the measurement it completes, then hold
    task automatic step(input int hold, input bit glitch, input bit expv,
                        input int top, input bit lk);
        exp_t e;
        sig_in = ~sig_in;
        if (expv) begin
            e.top = WIDTH'(top);
            e.lk  = lk;
            e.gt  = 1'b1;
            exp_q.push_back(e);
        end
        if (glitch) begin
            repeat (hold / 2) @(negedge clk);
            sig_in = ~sig_in;
            repeat (3) @(negedge clk);
            sig_in = ~sig_in;
            repeat (hold - hold / 2 - 3) @(negedge clk);
        end else begin
            repeat (hold) @(negedge clk);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("valid_top", 32'(counter_top), 32'(e.top));
                    check("valid_locked", 32'(locked), 32'(e.lk));
                    check("valid_gate", 32'(gate), 32'(e.gt));
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst    = 1'b1;
        sig_in = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_top", 32'(counter_top), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_locked", 32'(locked), 32'd0);
        check("reset_gate", 32'(gate), 32'd0);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        check("idle_top", 32'(counter_top), 32'd0);
        check("idle_locked", 32'(locked), 32'd0);
        check("idle_gate", 32'(gate), 32'd0);

        // Half-period 1000: arm, then lock on the fourth measurement
        step(1000, 0, 0,   0, 0);
        step(1000, 0, 1, 999, 0);
        step(1000, 0, 1, 999, 0);
        step(1000, 0, 1, 999, 0);
        step(1000, 0, 1, 999, 1);
        // 3-cycle glitch in the middle of this half-period is filtered out
        step(1000, 1, 1, 999, 1);
        step(1000, 0, 1, 999, 1);
        // 1020 stays within tolerance of 1000 and vice versa; 1040 does not
        step(1020, 0, 1, 999, 1);
        step(1000, 0, 1, 1019, 1);
        step(1040, 0, 1, 999, 1);
        step(500,  0, 1, 1039, 0);
        // Half-period 500: relock on the third following measurement
        step(500,  0, 1, 499, 0);
        step(500,  0, 1, 499, 1 == 0);
        step(500,  0, 1, 499, 0);
        step(500,  0, 1, 499, 1);

        // Hold the input: timeout lands 4095 cycles after the counter clear
        step(4050, 0, 1, 499, 1);
        check("pre_timeout_gate", 32'(gate), 32'd1);
        check("pre_timeout_locked", 32'(locked), 32'd1);
        repeat (100) @(negedge clk);
        check("timeout_gate", 32'(gate), 32'd0);
        check("timeout_locked", 32'(locked), 32'd0);
        check("timeout_top_hold", 32'(counter_top), 32'd499);

        // First edge after silence only arms, the next one measures
        step(600, 0, 0,   0, 0);
        check("rearm_gate", 32'(gate), 32'd0);
        step(600, 0, 1, 599, 0);

        // Reset in the middle of a measurement discards it
        rst    = 1'b1;
        sig_in = 1'b0;
        repeat (3) @(negedge clk);
        check("midreset_top", 32'(counter_top), 32'd0);
        check("midreset_gate", 32'(gate), 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        step(400, 0, 0,   0, 0);
        check("post_reset_arm_gate", 32'(gate), 32'd0);
        step(400, 0, 1, 399, 0);
        repeat (50) @(negedge clk);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
